// File: rtl/clock_pkg.sv
// Shared widths, limits and digit checks for the HH:MM:SS BCD time counter.
package clock_pkg;

    localparam int SEC_UNITS_W = 4;
    localparam int SEC_TENS_W  = 3;
    localparam int HOUR_TENS_W = 2;

    localparam int MAX_SEC  = 59;
    localparam int MAX_MIN  = 59;
    localparam int MAX_HOUR = 23;
    localparam int HOURS_12 = 12;

    function automatic logic bcd_ok(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

    // Valid BCD pair whose decimal value does not exceed max.
    function automatic logic field_ok(
        input logic [2:0] tens,
        input logic [3:0] units,
        input int         max
    );
        return bcd_ok(units) && ((int'(tens) * 10 + int'(units)) <= max);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter; priority reset > load > clear > inc.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MODULUS   = 60,
    parameter int TENS_W    = 3,
    parameter int RESET_VAL = 0
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Clear,
    input  logic                   i_Load,
    input  logic                   i_Inc,
    input  logic [SEC_UNITS_W-1:0] i_Load_Units,
    input  logic [TENS_W-1:0]      i_Load_Tens,
    output logic [SEC_UNITS_W-1:0] o_Units,
    output logic [TENS_W-1:0]      o_Tens,
    output logic                   o_Carry,
    output logic                   o_At_Max
);

    localparam logic [SEC_UNITS_W-1:0] MAX_U = SEC_UNITS_W'((MODULUS - 1) % 10);
    localparam logic [TENS_W-1:0]      MAX_T = TENS_W'((MODULUS - 1) / 10);
    localparam logic [SEC_UNITS_W-1:0] RST_U = SEC_UNITS_W'(RESET_VAL % 10);
    localparam logic [TENS_W-1:0]      RST_T = TENS_W'(RESET_VAL / 10);

    assign o_At_Max = (o_Units == MAX_U) && (o_Tens == MAX_T);
    assign o_Carry  = i_Inc && o_At_Max;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Units <= RST_U;
            o_Tens  <= RST_T;
        end else if (i_Load) begin
            o_Units <= i_Load_Units;
            o_Tens  <= i_Load_Tens;
        end else if (i_Clear) begin
            o_Units <= '0;
            o_Tens  <= '0;
        end else if (i_Inc) begin
            if (o_At_Max) begin
                o_Units <= '0;
                o_Tens  <= '0;
            end else if (o_Units == 4'd9) begin
                o_Units <= '0;
                o_Tens  <= o_Tens + TENS_W'(1);
            end else begin
                o_Units <= o_Units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with prescaler, validated load,
// manual set, 12 h display decode and day-wrap strobe.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int RESET_HOUR    = 0,
    parameter int MANUAL_CARRY  = 0
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Run,
    input  logic                   i_Tick,
    input  logic                   i_Clear_Sec,
    input  logic                   i_Inc_Sec,
    input  logic                   i_Inc_Min,
    input  logic                   i_Inc_Hour,
    input  logic                   i_Load,
    input  logic [5:0]             i_Load_Hour,
    input  logic [6:0]             i_Load_Min,
    input  logic [6:0]             i_Load_Sec,
    input  logic                   i_Mode_12h,
    output logic [SEC_UNITS_W-1:0] o_Units_Sec,
    output logic [SEC_TENS_W-1:0]  o_Tens_Sec,
    output logic [SEC_UNITS_W-1:0] o_Units_Min,
    output logic [SEC_TENS_W-1:0]  o_Tens_Min,
    output logic [SEC_UNITS_W-1:0] o_Units_Hour,
    output logic [HOUR_TENS_W-1:0] o_Tens_Hour,
    output logic                   o_PM,
    output logic                   o_Day_Wrap,
    output logic                   o_Load_Error
);

    localparam logic [15:0] PRE_TOP = 16'(TICKS_PER_SEC - 1);

    logic [15:0]            pre;
    logic                   manual, tick_ok, sec_adv, carry_en;
    logic                   load_ok, wr, sec_clr;
    logic                   sec_inc, min_inc, hour_inc;
    logic                   sec_carry, min_carry, hour_carry;
    logic                   sec_max, min_max, hour_max, unused_max;
    logic [SEC_UNITS_W-1:0] hour_units, units12;
    logic [HOUR_TENS_W-1:0] hour_tens;
    logic [4:0]             hour_bin, disp;
    logic                   tens12;

    assign load_ok = field_ok({1'b0, i_Load_Hour[5:4]}, i_Load_Hour[3:0], MAX_HOUR)
                  && field_ok(i_Load_Min[6:4], i_Load_Min[3:0], MAX_MIN)
                  && field_ok(i_Load_Sec[6:4], i_Load_Sec[3:0], MAX_SEC);

    assign manual   = i_Clear_Sec | i_Inc_Sec | i_Inc_Min | i_Inc_Hour;
    assign tick_ok  = i_Run & i_Tick & ~i_Load & ~manual;
    assign sec_adv  = tick_ok & (pre == PRE_TOP);
    assign carry_en = (MANUAL_CARRY != 0) | tick_ok;
    assign wr       = i_Load & load_ok;
    assign sec_clr  = ~i_Load & i_Clear_Sec;

    assign sec_inc  = ~i_Load & ((i_Inc_Sec & ~i_Clear_Sec) | sec_adv);
    assign min_inc  = ~i_Load & (i_Inc_Min | (sec_carry & carry_en));
    assign hour_inc = ~i_Load & (i_Inc_Hour | (min_carry & carry_en));

    // Wrap detection uses the carry path; the max flags are kept for probing.
    assign unused_max = sec_max ^ min_max ^ hour_max;

    bcd_mod_counter #(.MODULUS(MAX_SEC + 1), .TENS_W(SEC_TENS_W), .RESET_VAL(0)) u_sec (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Clear(sec_clr), .i_Load(wr),
        .i_Inc(sec_inc), .i_Load_Units(i_Load_Sec[3:0]), .i_Load_Tens(i_Load_Sec[6:4]),
        .o_Units(o_Units_Sec), .o_Tens(o_Tens_Sec), .o_Carry(sec_carry), .o_At_Max(sec_max)
    );

    bcd_mod_counter #(.MODULUS(MAX_MIN + 1), .TENS_W(SEC_TENS_W), .RESET_VAL(0)) u_min (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Clear(1'b0), .i_Load(wr),
        .i_Inc(min_inc), .i_Load_Units(i_Load_Min[3:0]), .i_Load_Tens(i_Load_Min[6:4]),
        .o_Units(o_Units_Min), .o_Tens(o_Tens_Min), .o_Carry(min_carry), .o_At_Max(min_max)
    );

    bcd_mod_counter #(.MODULUS(MAX_HOUR + 1), .TENS_W(HOUR_TENS_W), .RESET_VAL(RESET_HOUR)) u_hour (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Clear(1'b0), .i_Load(wr),
        .i_Inc(hour_inc), .i_Load_Units(i_Load_Hour[3:0]), .i_Load_Tens(i_Load_Hour[5:4]),
        .o_Units(hour_units), .o_Tens(hour_tens), .o_Carry(hour_carry), .o_At_Max(hour_max)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            pre          <= '0;
            o_Day_Wrap   <= 1'b0;
            o_Load_Error <= 1'b0;
        end else begin
            if (wr || sec_clr)
                pre <= '0;
            else if (tick_ok)
                pre <= (pre == PRE_TOP) ? '0 : pre + 16'd1;
            o_Day_Wrap   <= tick_ok & hour_carry;
            o_Load_Error <= i_Load & ~load_ok;
        end
    end

    assign hour_bin = {3'b000, hour_tens} * 5'd10 + {1'b0, hour_units};
    assign o_PM     = hour_bin >= 5'(HOURS_12);

    always_comb begin
        disp = hour_bin;
        if (hour_bin == 5'd0)
            disp = 5'(HOURS_12);
        else if (hour_bin > 5'(HOURS_12))
            disp = hour_bin - 5'(HOURS_12);
        tens12  = disp >= 5'd10;
        units12 = tens12 ? 4'(disp - 5'd10) : 4'(disp);
    end

    assign o_Tens_Hour  = i_Mode_12h ? {1'b0, tens12} : hour_tens;
    assign o_Units_Hour = i_Mode_12h ? units12 : hour_units;

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Parametrised HH:MM:SS BCD time-of-day counter chain, successor to `clock_counters`. It adds:
- an internal tick prescaler,
- run-time 12/24-hour display mode,
- validated parallel load,
- per-field manual increment with selectable carry,
- a day-wrap strobe.

It sits between the 1 Hz (or faster) tick generator and the display/mode-control logic of the clock.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 1: number of accepted `i_Tick` strobes per one-second advance; range 1..65535.
- `RESET_HOUR`, default 0: binary hour (0..23) loaded on reset; minutes and seconds reset to 0.
- `MANUAL_CARRY`, default 0: 0 = manual increment wraps its field only; 1 = manual increment carries into the next field, same as the tick path.

Ports:
- `i_Clock`  in  1  single clock.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Run`  in  1  qualifies `i_Tick`; 0 freezes time-keeping.
- `i_Tick`  in  1  one-cycle timebase strobe.
- `i_Clear_Sec`  in  1  clears seconds and the prescaler.
- `i_Inc_Sec` / `i_Inc_Min` / `i_Inc_Hour`  in  1 each  manual +1 on that field.
- `i_Load`  in  1  parallel load strobe.
- `i_Load_Hour`  in  6  BCD {tens[1:0], units[3:0]}, 24 h format.
- `i_Load_Min`, `i_Load_Sec`  in  7 each  BCD {tens[2:0], units[3:0]}.
- `i_Mode_12h`  in  1  display hours as 12 h with a PM flag.
- `o_Units_Sec` out 4, `o_Tens_Sec` out 3, `o_Units_Min` out 4, `o_Tens_Min` out 3, `o_Units_Hour` out 4, `o_Tens_Hour` out 2: BCD time digits.
- `o_PM`  out  1  set when the internal hour ≥ 12; valid in both modes.
- `o_Day_Wrap`  out  1  one-cycle pulse on a tick-driven 23:59:59→00:00:00.
- `o_Load_Error`  out  1  one-cycle pulse when a load is rejected.

## Operation
- State: seconds 0..59, minutes 0..59, hours 0..23 (always 24 h internally), prescaler 0..TICKS_PER_SEC-1.
- Reset:
  - time = RESET_HOUR:00:00; prescaler = 0.
  - `o_Day_Wrap` = 0 and `o_Load_Error` = 0.
  - `o_PM` = (RESET_HOUR ≥ 12).
- Per-cycle priority: `i_Reset` > `i_Load` > (`i_Clear_Sec`, manual increments) > tick.
- Load:
  - Every digit must be valid BCD, hour ≤ 23, and min/sec ≤ 59.
  - If valid: all fields are written and the prescaler is cleared.
  - If invalid: nothing changes and `o_Load_Error` pulses.
  - All other inputs are ignored in a load cycle.
- `i_Clear_Sec`: seconds = 0, prescaler = 0. Minutes and hours are unaffected unless a manual increment is asserted for them.
- Manual increments:
  - Applied in the same cycle and independent per field.
  - With MANUAL_CARRY=0: 59→0 and 23→0 with no carry.
  - With MANUAL_CARRY=1: a ripple carry follows the tick rules, but `o_Day_Wrap` is not raised.
  - `i_Inc_Sec` together with `i_Clear_Sec`: clear wins.
- Tick:
  - Accepted when `i_Run` & `i_Tick` and none of load, clear, or inc is asserted. Otherwise the tick is discarded and the prescaler holds.
  - An accepted tick increments the prescaler. At TICKS_PER_SEC-1 the prescaler returns to 0 and seconds advance.
  - The carry chain is 59→0 (sec) → min+1; 59→0 (min) → hour+1; 23→0 (hour) → `o_Day_Wrap`.
- 12 h display, decoded combinationally from the hour register:
  - hour 0 shows 12.
  - hours 1..12 show unchanged.
  - hours 13..23 show hour-12.
- The mode bit never alters stored time.

## Timing
- Every state change is visible on the outputs after the `i_Clock` edge that samples the causing input; latency is 1 cycle.
- Digit outputs are combinational decodes of registers. A change on `i_Mode_12h` is reflected in the same cycle.
- `o_Day_Wrap` and `o_Load_Error` are registered and high for exactly one cycle, after the same edge that updates the time.
- Back-to-back ticks on every cycle are supported; every cycle can advance. With TICKS_PER_SEC=1, 86400 cycles is one full day.
- A reset in mid-carry discards the carry; no pulse is produced.

## Structure
- Package `clock_pkg`:
  - field widths (SEC_UNITS_W=4, SEC_TENS_W=3, HOUR_TENS_W=2);
  - limits MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23, HOURS_12=12;
  - a BCD-validity function.
- Sub-module `bcd_mod_counter`:
  - Parameter MODULUS; two-digit BCD field.
  - Ports: clear, load, inc; outputs `o_Carry` and `o_At_Max`.
  - Instantiated three times: 60, 60, 24.
- Prescaler, priority logic and 12 h decode live in the top level.

## Test plan
- Reset with RESET_HOUR=7 → 07:00:00, `o_PM`=0. TICKS_PER_SEC=4 and 8 consecutive ticks → 07:00:02.
- Load 23:59:58, then 2 seconds of ticks → 00:00:00 with a single `o_Day_Wrap` pulse on the wrap edge. Load 12:60:00 → `o_Load_Error` pulse and time unchanged.
- MANUAL_CARRY=0, time 10:59:00, `i_Inc_Min` → 10:00:00. With MANUAL_CARRY=1 the same stimulus → 11:00:00, and `o_Day_Wrap` stays low from 23:59 +min.
- Hours 00, 12, 13, 23 with `i_Mode_12h`=1 → display 12/AM, 12/PM, 01/PM, 11/PM. Toggling the mode leaves the registers unchanged.
- Tick coincident with `i_Inc_Hour` → hour +1, seconds and prescaler unchanged. `i_Run`=0 with 100 ticks → no change.
- `i_Clear_Sec` at 12:34:56 mid-prescale, then TICKS_PER_SEC ticks → 12:34:01. A reset asserted together with `i_Load` → reset value wins.
